uart_rx: RTL

//   UART receiver, directly downstream of the baud rate generator; consumes its 16x-oversample tick.

---
 rtl/uart_rx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, LSB-first, 1 start / N data / stop.
//            Define UART_RX_PARITY_EN to add a parity bit and parity_err port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int SW = (SB_TICKS > 16) ? 5 : 4;
    localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] C_S_MID  = SW'(7);
    localparam logic [SW-1:0] C_S_LAST = SW'(15);
    localparam logic [SW-1:0] C_S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] C_N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
        ,
        PARITY = 3'd4
`endif
    } state_t;

    state_t                 state_q,     state_d;
    logic                   rx_meta_q,   rx_meta_d;
    logic                   rx_s_q,      rx_s_d;
    logic [SW-1:0]          s_q,         s_d;
    logic [NW-1:0]          n_q,         n_d;
    logic [DATA_BITS-1:0]   sreg_q,      sreg_d;
    logic [DATA_BITS-1:0]   rx_data_q,   rx_data_d;
    logic                   rx_done_q,   rx_done_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    localparam logic C_PAR_ODD = 1'(PARITY_ODD);
    logic                   pbit_q,       pbit_d;
    logic                   parity_err_q, parity_err_d;
`endif

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        sreg_d      = sreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
        pbit_d       = pbit_q;
        parity_err_d = parity_err_q;
`endif
        case (state_q)
            // Start detection is edge-driven; only the later states wait for ticks.
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == C_S_MID) begin
                        s_d = '0;
                        if (!rx_s_q) begin
                            state_d = DATA;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == C_S_LAST) begin
                        s_d    = '0;
                        sreg_d = {rx_s_q, sreg_q[DATA_BITS-1:1]};
                        if (n_q == C_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == C_S_LAST) begin
                        s_d     = '0;
                        pbit_d  = rx_s_q;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            // Frames with a bad stop bit are still delivered, flagged by frame_err.
            STOP: begin
                if (s_tick) begin
                    if (s_q == C_S_STOP) begin
                        s_d         = '0;
                        state_d     = IDLE;
                        rx_data_d   = sreg_q;
                        rx_done_d   = 1'b1;
                        frame_err_d = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = (^sreg_q) ^ pbit_q ^ C_PAR_ODD;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            s_q         <= '0;
            n_q         <= '0;
            sreg_q      <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            s_q         <= s_d;
            n_q         <= n_d;
            sreg_q      <= sreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            pbit_q       <= pbit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire
